// File: rtl/cache_pkg.sv
// Shared types and field positions for the 2-way data-cache controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;
  localparam int TAG_W     = 23;
  localparam int IDX_W     = 4;
  localparam int LINE_W    = 256;
  localparam int WORD_W    = 32;
  localparam int OFF_W     = 3;
  localparam int TAGWORD_W = TAG_W + 2;
  localparam int VALID_BIT = 24;
  localparam int DIRTY_BIT = 23;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    FILL      = 2'd3
  } state_t;
endpackage

// File: rtl/dcache_word_merge.sv
// Extracts one 32-bit word from a cache line and builds the line with that word replaced.
// Latency: combinational.
// Backpressure: none.
module dcache_word_merge
  import cache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [OFF_W-1:0]  offset,
  input  logic [WORD_W-1:0] wr_word,
  output logic [WORD_W-1:0] rd_word,
  output logic [LINE_W-1:0] merged
);
  // Word w sits at bits [32w+31:32w], so the bit base is offset*32.
  logic [7:0] base;
  assign base = {offset, 5'b0};

  // Read the selected word and overlay the store word onto a copy of the line.
  always_comb begin
    rd_word = line[base +: WORD_W];
    merged  = line;
    merged[base +: WORD_W] = wr_word;
  end
endmodule

// File: rtl/dcache_controller.sv
// Sequences hits, dirty write-back, refill and fill for a passive 2-way cache SRAM.
// Latency: hits respond in the request cycle; misses stall for detect + mem + fill cycles.
// Backpressure: cpu_stall_o holds the CPU; memory requests are held until mem_ack_i.
module dcache_controller
  import cache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_write_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [WORD_W-1:0]    cpu_data_i,
  output logic [WORD_W-1:0]    cpu_data_o,
  output logic                 cpu_stall_o,
  output logic [IDX_W-1:0]     sram_addr_o,
  output logic [TAGWORD_W-1:0] sram_tag_o,
  output logic [LINE_W-1:0]    sram_data_o,
  output logic                 sram_enable_o,
  output logic                 sram_write_o,
  input  logic [TAGWORD_W-1:0] sram_tag_i,
  input  logic [LINE_W-1:0]    sram_data_i,
  input  logic                 sram_hit_i,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_W-1:0]    mem_data_o,
  input  logic [LINE_W-1:0]    mem_data_i,
  input  logic                 mem_ack_i
);
  state_t state, state_d;

  logic [TAG_W-1:0]  victim_tag_q;
  logic [LINE_W-1:0] victim_line_q;
  logic [LINE_W-1:0] refill_line_q;

  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic [OFF_W-1:0]  cpu_off;
  logic [WORD_W-1:0] hit_word;
  logic [LINE_W-1:0] hit_merged;
  logic              miss_detect;
  logic              unused_byte_bits;

  assign cpu_tag          = cpu_addr_i[31:9];
  assign cpu_idx          = cpu_addr_i[8:5];
  assign cpu_off          = cpu_addr_i[4:2];
  assign unused_byte_bits = ^cpu_addr_i[1:0];
  assign miss_detect      = (state == IDLE) && cpu_req_i && !sram_hit_i;

  dcache_word_merge u_merge (
    .line    (sram_data_i),
    .offset  (cpu_off),
    .wr_word (cpu_data_i),
    .rd_word (hit_word),
    .merged  (hit_merged)
  );

  // State register plus the victim and refill line buffers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      victim_tag_q  <= '0;
      victim_line_q <= '0;
      refill_line_q <= '0;
    end else begin
      state <= state_d;
      if (miss_detect) begin
        victim_tag_q  <= sram_tag_i[TAG_W-1:0];
        victim_line_q <= sram_data_i;
      end
      if (state == REFILL && mem_ack_i) begin
        refill_line_q <= mem_data_i;
      end
    end
  end

  // Next state and all outputs; everything is forced low while reset is held.
  always_comb begin
    state_d       = state;
    cpu_data_o    = '0;
    cpu_stall_o   = 1'b0;
    sram_addr_o   = '0;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (cpu_req_i) begin
            sram_enable_o = 1'b1;
            sram_addr_o   = cpu_idx;
            sram_tag_o    = {1'b1, 1'b0, cpu_tag};
            if (sram_hit_i) begin
              if (cpu_write_i) begin
                sram_write_o = 1'b1;
                sram_data_o  = hit_merged;
                sram_tag_o   = {1'b1, 1'b1, cpu_tag};
              end else begin
                cpu_data_o = hit_word;
              end
            end else begin
              cpu_stall_o = 1'b1;
              if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) state_d = WRITEBACK;
              else                                                state_d = REFILL;
            end
          end
        end
        WRITEBACK: begin
          cpu_stall_o  = 1'b1;
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = {victim_tag_q, cpu_idx, 5'b0};
          mem_data_o   = victim_line_q;
          if (mem_ack_i) state_d = REFILL;
        end
        REFILL: begin
          cpu_stall_o  = 1'b1;
          mem_enable_o = 1'b1;
          mem_addr_o   = {cpu_tag, cpu_idx, 5'b0};
          if (mem_ack_i) state_d = FILL;
        end
        FILL: begin
          cpu_stall_o   = 1'b1;
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_addr_o   = cpu_idx;
          sram_tag_o    = {1'b1, 1'b0, cpu_tag};
          sram_data_o   = refill_line_q;
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: 2-way SRAM model, latency-3 memory, load-data scoreboard.
// Latency: memory acks after 3 cycles of a held request.
// Backpressure: accesses are held until cpu_stall_o drops.
module tb_dcache_controller;
  import cache_pkg::*;

  localparam int MEM_LAT = 3;
  localparam int NVEC    = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_write;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_enable_o, sram_write_o, sram_hit_i;
  logic         mem_enable_o, mem_write_o, mem_ack;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_in;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_write_i(cpu_write), .cpu_addr_i(cpu_addr),
    .cpu_data_i(cpu_wdata), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_in), .mem_ack_i(mem_ack)
  );

  // ---------------- 2-way SRAM model (LRU victim, invalid ways first) ----------------
  logic [24:0]  s_tag  [16][2];
  logic [255:0] s_line [16][2];
  logic         s_lru  [16];
  logic         sram_clr;
  logic         m_hit, m_sel, m_vic;
  int           sram_wr_cnt = 0;

  // Lookup: hit way if any, otherwise the victim way.
  always_comb begin
    m_hit = 1'b0;
    m_sel = 1'b0;
    m_vic = !s_tag[sram_addr_o][0][24] ? 1'b0 :
            (!s_tag[sram_addr_o][1][24] ? 1'b1 : s_lru[sram_addr_o]);
    for (int w = 0; w < 2; w++) begin
      if (s_tag[sram_addr_o][w][24] && s_tag[sram_addr_o][w][22:0] == sram_tag_o[22:0]) begin
        m_hit = 1'b1;
        m_sel = w[0];
      end
    end
    if (!m_hit) m_sel = m_vic;
    sram_tag_i  = s_tag[sram_addr_o][m_sel];
    sram_data_i = s_line[sram_addr_o][m_sel];
    sram_hit_i  = m_hit;
  end

  // Array update: writes land in the selected way; hits and fills refresh LRU.
  always @(posedge clk) begin
    if (sram_clr) begin
      for (int s = 0; s < 16; s++) begin
        s_lru[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          s_tag[s][w]  <= '0;
          s_line[s][w] <= '0;
        end
      end
    end else if (sram_enable_o) begin
      if (sram_write_o) begin
        s_tag[sram_addr_o][m_sel]  <= sram_tag_o;
        s_line[sram_addr_o][m_sel] <= sram_data_o;
        s_lru[sram_addr_o]         <= ~m_sel;
        sram_wr_cnt                <= sram_wr_cnt + 1;
      end else if (m_hit) begin
        s_lru[sram_addr_o] <= ~m_sel;
      end
    end
  end

  // ---------------- backing memory and reference word model ----------------
  logic [255:0] mem_lines [logic [31:0]];
  logic [31:0]  ref_words [logic [31:0]];
  logic [31:0]  sb_q [$];
  logic         mem_auto;

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] a);
    logic [255:0] l;
    logic [2:0]   wi;
    if (mem_lines.exists(a)) return mem_lines[a];
    for (int w = 0; w < 8; w++) begin
      wi = w[2:0];
      l[w*32 +: 32] = def_word({a[31:5], wi, 2'b00});
    end
    return l;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (ref_words.exists(wa)) return ref_words[wa];
    return def_word(wa);
  endfunction

  // Memory responder: ack after MEM_LAT cycles of a held request.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_data_in = '0;
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        mem_ack = 1'b0;
        if (mem_enable_o) begin
          cnt++;
          if (cnt == MEM_LAT) begin
            cnt = 0;
            mem_ack = 1'b1;
            if (mem_write_o) mem_lines[mem_addr_o] = mem_data_o;
            else             mem_data_in = get_line(mem_addr_o);
          end
        end else begin
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Write-back observer.
  int           wb_cnt = 0;
  int           memw_cyc = 0;
  logic [31:0]  wb_addr;
  logic [255:0] wb_line;
  always @(posedge clk) begin
    if (mem_enable_o && mem_write_o) memw_cyc <= memw_cyc + 1;
    if (mem_enable_o && mem_write_o && mem_ack) begin
      wb_cnt  <= wb_cnt + 1;
      wb_addr <= mem_addr_o;
      wb_line <= mem_data_o;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int stalls);
    logic [31:0] exp_d;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_write = w;
    cpu_addr  = a;
    cpu_wdata = d;
    if (w) ref_words[{a[31:2], 2'b00}] = d;
    else   sb_q.push_back(ref_read(a));
    stalls = 0;
    #1;
    while (cpu_stall_o && stalls < 60) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (cpu_stall_o) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: addr %0h still stalled after %0d cycles", a, stalls);
      if (!w) exp_d = sb_q.pop_front();
    end else if (!w) begin
      exp_d = sb_q.pop_front();
      check("load_data", {224'b0, cpu_data_o}, {224'b0, exp_d});
    end
    @(posedge clk);
    #1;
    cpu_req   = 1'b0;
    cpu_write = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_stall;
    int          exp_wb;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, wb0, mw0, wr0;
    vecs[0]  = '{1'b0, 32'h0000_0040, 32'h0,          5, 0};
    vecs[1]  = '{1'b1, 32'h0000_0044, 32'h1234_5678,  0, 0};
    vecs[2]  = '{1'b0, 32'h0000_0044, 32'h0,          0, 0};
    vecs[3]  = '{1'b0, 32'h0000_0240, 32'h0,          5, 0};
    vecs[4]  = '{1'b0, 32'h0000_0440, 32'h0,          8, 1};
    vecs[5]  = '{1'b0, 32'h0000_0044, 32'h0,          5, 0};
    vecs[6]  = '{1'b0, 32'h0000_0440, 32'h0,          0, 0};
    vecs[7]  = '{1'b1, 32'h0000_0448, 32'hCAFE_0001,  0, 0};
    vecs[8]  = '{1'b0, 32'h0000_0044, 32'h0,          0, 0};
    vecs[9]  = '{1'b1, 32'h0000_0040, 32'h0BAD_F00D,  0, 0};
    vecs[10] = '{1'b0, 32'h0000_0448, 32'h0,          0, 0};
    vecs[11] = '{1'b0, 32'h0000_0040, 32'h0,          0, 0};
    vecs[12] = '{1'b1, 32'h0000_1064, 32'h55AA_55AA,  5, 0};
    vecs[13] = '{1'b0, 32'h0000_1064, 32'h0,          0, 0};

    mem_lines[32'h40] = get_line(32'h40);
    mem_lines[32'h40][31:0] = 32'hDEAD_BEEF;
    ref_words[32'h40] = 32'hDEAD_BEEF;

    // Reset with a request applied: every output must stay low.
    mem_auto  = 1'b1;
    rst       = 1'b1;
    sram_clr  = 1'b1;
    cpu_req   = 1'b1;
    cpu_write = 1'b1;
    cpu_addr  = 32'h40;
    cpu_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_stall",     {255'b0, cpu_stall_o},   256'd0);
    check("rst_sram_en",   {255'b0, sram_enable_o}, 256'd0);
    check("rst_sram_wr",   {255'b0, sram_write_o},  256'd0);
    check("rst_mem_en",    {255'b0, mem_enable_o},  256'd0);
    check("rst_cpu_data",  {224'b0, cpu_data_o},    256'd0);
    rst       = 1'b0;
    sram_clr  = 1'b0;
    cpu_req   = 1'b0;
    cpu_write = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      wb0 = wb_cnt;
      mw0 = memw_cyc;
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].data, st);
      check("stall_cycles",   st,                vecs[i].exp_stall);
      check("writebacks",     wb_cnt - wb0,      vecs[i].exp_wb);
      check("memwrite_cycles", memw_cyc - mw0,   vecs[i].exp_wb * MEM_LAT);
      if (i == 2) begin
        check("dirty_bit", {255'b0, s_tag[2][0][23]}, 256'd1);
        check("dirty_tag", {233'b0, s_tag[2][0][22:0]}, 256'd0);
      end
      if (i == 4) begin
        check("wb_addr",  {224'b0, wb_addr},        256'h40);
        check("wb_word1", {224'b0, wb_line[63:32]}, 256'h1234_5678);
        check("wb_word0", {224'b0, wb_line[31:0]},  256'hDEAD_BEEF);
      end
    end

    // Reset in REFILL with the ack still pending.
    mem_auto = 1'b0;
    mem_ack  = 1'b0;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 32'h2080;
    #1;
    check("abort_detect_stall", {255'b0, cpu_stall_o}, 256'd1);
    @(negedge clk);
    #1;
    check("abort_refill_en",   {255'b0, mem_enable_o}, 256'd1);
    check("abort_refill_wr",   {255'b0, mem_write_o},  256'd0);
    check("abort_refill_addr", {224'b0, mem_addr_o},   256'h2080);
    wr0 = sram_wr_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    cpu_req     = 1'b0;
    mem_ack     = 1'b1;
    mem_data_in = {8{32'hBADB_AD00}};
    #1;
    check("abort_mem_en",  {255'b0, mem_enable_o}, 256'd0);
    check("abort_stall",   {255'b0, cpu_stall_o},  256'd0);
    check("abort_sram_wr", {255'b0, sram_write_o}, 256'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("late_ack_mem_en", {255'b0, mem_enable_o}, 256'd0);
    check("late_ack_stall",  {255'b0, cpu_stall_o},  256'd0);
    check("abort_no_sram_write", sram_wr_cnt - wr0, 256'd0);
    mem_auto = 1'b1;
    do_access(1'b0, 32'h44, 32'h0, st);
    check("post_abort_hit_stall", st, 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
